// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its fetch/execute reader.
// Opcodes, operands, addresses, instruction words, results and FSM states.
package instr_register_pkg;

  localparam int NUM_INSTR = 32;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_FETCH = 3'd1,
    FS_EXEC  = 3'd2,
    FS_OUT   = 3'd3,
    FS_DONE  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_exec_if.sv
// Valid/ready result stream from the fetch/execute block to its consumer.
interface instr_fetch_exec_if;
  import instr_register_pkg::*;

  logic     res_valid;
  logic     res_ready;
  result_t  result;
  opcode_t  res_opcode;
  address_t res_addr;
  logic     div_by_zero;

  modport master (
    output res_valid,
    output result,
    output res_opcode,
    output res_addr,
    output div_by_zero,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  result,
    input  res_opcode,
    input  res_addr,
    input  div_by_zero,
    output res_ready
  );

endinterface

// File: rtl/instr_fetch_exec_alu.sv
// Combinational executor: one instruction word in, 64-bit signed result out.
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t instr,
  output result_t      result,
  output logic         div_by_zero
);

  result_t op_a;
  result_t op_b;

  assign op_a = {{32{instr.op_a[31]}}, instr.op_a};
  assign op_b = {{32{instr.op_b[31]}}, instr.op_b};

  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (instr.opc)
      ZERO:  result = '0;
      PASSA: result = op_a;
      PASSB: result = op_b;
      ADD:   result = op_a + op_b;
      SUB:   result = op_a - op_b;
      MULT:  result = op_a * op_b;
      // Division by zero is flagged rather than evaluated.
      DIV: begin
        if (op_b == '0) div_by_zero = 1'b1;
        else            result = op_a / op_b;
      end
      MOD: begin
        if (op_b == '0) div_by_zero = 1'b1;
        else            result = op_a % op_b;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_exec.sv
// Walks a run of instruction-register entries, executes each word and
// streams the results over a valid/ready interface.
module instr_fetch_exec
  import instr_register_pkg::*;
#(
  parameter int DEPTH = NUM_INSTR,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  address_t           first_addr,
  input  logic [CNT_W-1:0]   count,
  output address_t           read_pointer,
  input  instruction_t       instruction_word,
  instr_fetch_exec_if.master res,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] S_IDLE  = FS_IDLE;
  localparam logic [2:0] S_FETCH = FS_FETCH;
  localparam logic [2:0] S_EXEC  = FS_EXEC;
  localparam logic [2:0] S_OUT   = FS_OUT;
  localparam logic [2:0] S_DONE  = FS_DONE;

  logic [2:0]       state;
  logic [2:0]       state_next;
  address_t         ptr;
  address_t         ptr_inc;
  logic [CNT_W-1:0] remaining;
  instruction_t     ir;
  result_t          alu_result;
  logic             alu_div_by_zero;

  instr_alu u_alu (
    .instr       (ir),
    .result      (alu_result),
    .div_by_zero (alu_div_by_zero)
  );

  assign ptr_inc = (ptr == address_t'(DEPTH - 1)) ? '0 : ptr + address_t'(1);

  assign res.res_valid = (state == S_OUT);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (count == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC:  state_next = S_OUT;
      S_OUT:   if (res.res_ready)
                 state_next = (remaining == CNT_W'(1)) ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      ptr              <= '0;
      remaining        <= '0;
      ir               <= '0;
      read_pointer     <= '0;
      res.result       <= '0;
      res.res_opcode   <= ZERO;
      res.res_addr     <= '0;
      res.div_by_zero  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (start) begin
          ptr       <= first_addr;
          remaining <= count;
        end
        S_FETCH: ir <= instruction_word;
        S_EXEC: begin
          res.result      <= alu_result;
          res.res_opcode  <= ir.opc;
          res.res_addr    <= ptr;
          res.div_by_zero <= alu_div_by_zero;
        end
        S_OUT: if (res.res_ready) begin
          ptr       <= ptr_inc;
          remaining <= remaining - CNT_W'(1);
        end
        default: ;
      endcase
      // The read address only moves when a fetch is about to happen.
      if (state_next == S_FETCH)
        read_pointer <= (state == S_IDLE) ? first_addr : ptr_inc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_exec.sv
// Directed bench for instr_fetch_exec: queue-based result model plus
// hand-computed expectations for timing, wrap, division and backpressure.
module tb_instr_fetch_exec;
  import instr_register_pkg::*;

  typedef struct {
    longint   res;
    address_t addr;
    opcode_t  opc;
    bit       dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  address_t     first_addr;
  logic [5:0]   count;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         busy;
  logic         done;

  instruction_t mem [NUM_INSTR];
  exp_t         exp_q [$];
  exp_t         obs_q [$];

  int checks = 0;
  int errors = 0;

  instr_fetch_exec_if bus ();

  instr_fetch_exec #(.DEPTH(32), .CNT_W(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res              (bus),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  task automatic check(input string name, input longint act, input longint want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    instruction_t r;
    r.opc  = o;
    r.op_a = a;
    r.op_b = b;
    return r;
  endfunction

  // Expected outcome of one register entry, from the opcode rules.
  function automatic exp_t model(input address_t ad);
    exp_t   e;
    longint a;
    longint b;
    a     = longint'($signed(mem[ad].op_a));
    b     = longint'($signed(mem[ad].op_b));
    e.addr = ad;
    e.opc  = mem[ad].opc;
    e.dbz  = 1'b0;
    e.res  = 0;
    case (mem[ad].opc)
      PASSA: e.res = a;
      PASSB: e.res = b;
      ADD:   e.res = a + b;
      SUB:   e.res = a - b;
      MULT:  e.res = a * b;
      DIV:   if (b == 0) e.dbz = 1'b1; else e.res = a / b;
      MOD:   if (b == 0) e.dbz = 1'b1; else e.res = a % b;
      default: e.res = 0;
    endcase
    return e;
  endfunction

  // Per-cycle compare: handshakes against the model, stability under stall.
  bit       held = 1'b0;
  result_t  held_result;
  address_t held_addr;
  opcode_t  held_opc;
  logic     held_dbz;

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      held = 1'b0;
    end else begin
      if (bus.res_valid)
        check("read_pointer_hold", longint'(read_pointer), longint'(bus.res_addr));
      if (held) begin
        check("stall_valid",  longint'(bus.res_valid), 1);
        check("stall_result", bus.result, held_result);
        check("stall_addr",   longint'(bus.res_addr), longint'(held_addr));
        check("stall_opcode", longint'(bus.res_opcode), longint'(held_opc));
        check("stall_dbz",    longint'(bus.div_by_zero), longint'(held_dbz));
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got addr %0d result %0d expected none",
                   bus.res_addr, bus.result);
        end else begin
          exp_t e;
          exp_t o;
          e = exp_q.pop_front();
          check("result",      bus.result, e.res);
          check("res_addr",    longint'(bus.res_addr), longint'(e.addr));
          check("res_opcode",  longint'(bus.res_opcode), longint'(e.opc));
          check("div_by_zero", longint'(bus.div_by_zero), longint'(e.dbz));
          o.res  = bus.result;
          o.addr = bus.res_addr;
          o.opc  = bus.res_opcode;
          o.dbz  = bus.div_by_zero;
          obs_q.push_back(o);
        end
      end
      held        = bus.res_valid && !bus.res_ready;
      held_result = bus.result;
      held_addr   = bus.res_addr;
      held_opc    = bus.res_opcode;
      held_dbz    = bus.div_by_zero;
    end
  end

  // Launch a run and watch it to completion; cycle c is the one after edge c.
  task automatic run(input address_t a, input int cnt, input int stall, input int spur,
                     input int exp_valid, input int exp_done, input int exp_hs);
    int fv;
    int dc;
    int hs;
    int stall_left;
    obs_q.delete();
    for (int i = 0; i < cnt; i++)
      exp_q.push_back(model(address_t'((int'(a) + i) % NUM_INSTR)));
    start      = 1'b1;
    first_addr = a;
    count      = 6'(cnt);
    @(posedge clk);
    #1;
    start      = 1'b0;
    first_addr = ~a;
    count      = '0;
    res_ready_drive(1'b1);
    fv = -1;
    dc = -1;
    hs = 0;
    stall_left = stall;
    for (int c = 1; c <= 400 && dc < 0; c++) begin
      @(negedge clk);
      if (bus.res_valid && fv < 0) fv = c;
      if (bus.res_valid && bus.res_ready) hs++;
      if (done) dc = c;
      @(posedge clk);
      #1;
      start = (c + 1 == spur);
      if (bus.res_valid && stall_left > 0) begin
        res_ready_drive(1'b0);
        stall_left--;
      end else begin
        res_ready_drive(1'b1);
      end
    end
    start = 1'b0;
    check("first_valid_cycle", fv, exp_valid);
    check("done_cycle", dc, exp_done);
    check("handshakes", hs, exp_hs);
    check("model_drained", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", longint'(done), 0);
    check("idle_after_done", longint'(busy), 0);
  endtask

  task automatic res_ready_drive(input logic v);
    bus.res_ready = v;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int vc;
    for (int i = 0; i < NUM_INSTR; i++) mem[i] = mk(ZERO, 0, 0);
    reset         = 1'b1;
    start         = 1'b0;
    first_addr    = '0;
    count         = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid",        longint'(bus.res_valid), 0);
    check("rst_busy",         longint'(busy), 0);
    check("rst_done",         longint'(done), 0);
    check("rst_result",       bus.result, 0);
    check("rst_read_pointer", longint'(read_pointer), 0);
    check("rst_res_addr",     longint'(bus.res_addr), 0);
    check("rst_dbz",          longint'(bus.div_by_zero), 0);
    @(posedge clk);
    #1;

    // Single ADD: valid in cycle 3, done in cycle 4.
    mem[3] = mk(ADD, 7, -10);
    run(5'd3, 1, 0, 0, 3, 4, 1);
    check("t1_result", obs_q[0].res, -3);
    check("t1_addr",   longint'(obs_q[0].addr), 3);

    // Four-entry run wrapping 31 -> 0, with a start pulse while busy.
    mem[30] = mk(MULT, 65536, 65536);
    mem[31] = mk(SUB, 0, 1);
    mem[0]  = mk(PASSB, 5, 9);
    mem[1]  = mk(ZERO, 1, 1);
    run(5'd30, 4, 0, 5, 3, 13, 4);
    check("wrap_r0", obs_q[0].res, 64'sd4294967296);
    check("wrap_r1", obs_q[1].res, -1);
    check("wrap_r2", obs_q[2].res, 9);
    check("wrap_r3", obs_q[3].res, 0);
    check("wrap_a1", longint'(obs_q[1].addr), 31);
    check("wrap_a2", longint'(obs_q[2].addr), 0);

    // Division, modulo, divide by zero and an undefined opcode.
    mem[10] = mk(DIV, -7, 2);
    mem[11] = mk(MOD, -7, 2);
    mem[12] = mk(DIV, 5, 0);
    mem[13] = mk(opcode_t'(4'hF), 3, 4);
    run(5'd10, 4, 0, 0, 3, 13, 4);
    check("div_res",    obs_q[0].res, -3);
    check("mod_res",    obs_q[1].res, -1);
    check("div0_res",   obs_q[2].res, 0);
    check("div0_flag",  longint'(obs_q[2].dbz), 1);
    check("div_flag",   longint'(obs_q[0].dbz), 0);
    check("undef_res",  obs_q[3].res, 0);

    // Backpressure: ten stalled cycles on the first result.
    mem[20] = mk(ADD, 100, 23);
    mem[21] = mk(MULT, -3, 5);
    run(5'd20, 2, 10, 0, 3, 17, 2);
    check("bp_r0", obs_q[0].res, 123);
    check("bp_r1", obs_q[1].res, -15);

    // Empty run: done in cycle 1, no result.
    run(5'd7, 0, 0, 0, -1, 1, 0);

    // Reset while a result is pending in OUT.
    mem[5] = mk(PASSA, 11, 0);
    mem[6] = mk(PASSA, 12, 0);
    bus.res_ready = 1'b0;
    start      = 1'b1;
    first_addr = 5'd5;
    count      = 6'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    vc = -1;
    for (int c = 1; c <= 10 && vc < 0; c++) begin
      @(negedge clk);
      if (bus.res_valid) vc = c;
    end
    check("rr_valid_cycle", vc, 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rr_valid",        longint'(bus.res_valid), 0);
    check("rr_busy",         longint'(busy), 0);
    check("rr_result",       bus.result, 0);
    check("rr_res_addr",     longint'(bus.res_addr), 0);
    check("rr_read_pointer", longint'(read_pointer), 0);
    check("rr_opcode",       longint'(bus.res_opcode), 0);
    vc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || bus.res_valid) vc++;
    end
    check("rr_no_done", vc, 0);
    @(posedge clk);
    #1;
    run(5'd3, 1, 0, 0, 3, 4, 1);
    check("rr_rerun_result", obs_q[0].res, -3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
